// File: rtl/dadda_mac_pkg.sv
// Shared widths, defaults and helper functions for the Dadda multiply-accumulate stage.
package dadda_mac_pkg;
  localparam int OP_W      = 16;
  localparam int PROD_W    = 32;
  localparam int ACC_W_DEF = 40;
  localparam int LEN_DEF   = 8;

  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  localparam int CNT_W = cnt_width(LEN_DEF);

  // Dadda height targets, applied from the tallest stage down to the final two rows.
  localparam int DADDA_STAGES = 6;

  function automatic int dadda_target(input int stage);
    case (stage)
      0:       return 13;
      1:       return 9;
      2:       return 6;
      3:       return 4;
      4:       return 3;
      default: return 2;
    endcase
  endfunction
endpackage

// File: rtl/dadda_mac_accumulator_if.sv
// Operand input and result output ports of the multiply-accumulate stage.
interface dadda_mac_accumulator_if
  import dadda_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
);
  // A transfer happens on a rising edge where valid & ready are both high; a source holds
  // valid and its data until that edge, and ready may depend combinationally on the sink's state.
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   multpr;
  logic [OP_W-1:0]   multpcd;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              out_ovf;

  modport master (
    output clr, in_valid, multpr, multpcd, out_ready,
    input  in_ready, out_valid, acc_out, out_ovf
  );

  modport slave (
    input  clr, in_valid, multpr, multpcd, out_ready,
    output in_ready, out_valid, acc_out, out_ovf
  );
endinterface

// File: rtl/dadda_mac_accumulator_mult.sv
// 16x16 unsigned Dadda multiplier: AND-array partial products, Dadda column reduction, final adder.
module dadda_multiplier
  import dadda_mac_pkg::*;
(
  input  logic [OP_W-1:0]   multpr,
  input  logic [OP_W-1:0]   multpcd,
  output logic [PROD_W-1:0] product
);
  localparam int DEPTH = OP_W + 4;

  logic              mat [PROD_W][DEPTH];
  logic              nxt [PROD_W][DEPTH];
  int                ht  [PROD_W];
  int                nht [PROD_W];
  logic [PROD_W-1:0] row;

  always_comb begin
    int   d;
    int   p;
    int   rem;
    int   tot;
    logic x;
    logic y;
    logic z;
    logic carry;
    d = 0; p = 0; rem = 0; tot = 0;
    x = 1'b0; y = 1'b0; z = 1'b0; carry = 1'b0;
    row = '0;
    product = '0;
    for (int i = 0; i < PROD_W; i++) begin
      ht[i]  = 0;
      nht[i] = 0;
      for (int j = 0; j < DEPTH; j++) begin
        mat[i][j] = 1'b0;
        nxt[i][j] = 1'b0;
      end
    end
    for (int a = 0; a < OP_W; a++) begin
      for (int b = 0; b < OP_W; b++) begin
        mat[a+b][ht[a+b]] = multpr[a] & multpcd[b];
        ht[a+b]++;
      end
    end
    // Carries from column i land in column i+1 of the same stage and count towards its height.
    for (int s = 0; s < DADDA_STAGES; s++) begin
      d = dadda_target(s);
      for (int i = 0; i < PROD_W; i++) nht[i] = 0;
      for (int i = 0; i < PROD_W; i++) begin
        p = 0;
        for (int k = 0; k < DEPTH; k++) begin
          rem = ht[i] - p;
          tot = rem + nht[i];
          if (tot > d && rem >= 2) begin
            x = mat[i][p];
            y = mat[i][p+1];
            if (tot == d + 1 || rem == 2) begin
              nxt[i][nht[i]] = x ^ y;
              carry = x & y;
              p += 2;
            end else begin
              z = mat[i][p+2];
              nxt[i][nht[i]] = x ^ y ^ z;
              carry = (x & y) | (x & z) | (y & z);
              p += 3;
            end
            nht[i]++;
            if (i < PROD_W - 1) begin
              nxt[i+1][nht[i+1]] = carry;
              nht[i+1]++;
            end
          end
        end
        for (int k = 0; k < DEPTH; k++) begin
          if (k >= p && k < ht[i]) begin
            nxt[i][nht[i]] = mat[i][k];
            nht[i]++;
          end
        end
      end
      mat = nxt;
      ht  = nht;
    end
    // Only the two surviving rows are non-constant, so this collapses to one carry-propagate adder.
    for (int r = 0; r < DEPTH; r++) begin
      for (int i = 0; i < PROD_W; i++) row[i] = (r < ht[i]) ? mat[i][r] : 1'b0;
      product = product + row;
    end
  end
endmodule

// File: rtl/dadda_mac_accumulator.sv
// Pipelined MAC: operand regs -> Dadda multiplier -> product reg -> frame accumulator -> result reg.
module dadda_mac_accumulator
  import dadda_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN   = LEN_DEF
)(
  input  logic                   clk,
  input  logic                   rst,
  dadda_mac_accumulator_if.slave bus
);
  localparam int CW = cnt_width(LEN);

  logic              stall;
  logic              accept;
  logic              v1;
  logic              v2;
  logic [OP_W-1:0]   s1_a;
  logic [OP_W-1:0]   s1_b;
  logic [PROD_W-1:0] mult_out;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [CW-1:0]     cnt;
  logic [ACC_W:0]    sum;
  logic              last;
  logic              frame_end;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall & ~bus.clr;
  assign accept       = bus.in_valid & bus.in_ready;
  assign sum          = {1'b0, acc} + (ACC_W+1)'(prod);
  assign last         = (cnt == CW'(LEN - 1));
  assign frame_end    = ~bus.clr & ~stall & v2 & last;

  dadda_multiplier u_mult (
    .multpr  (s1_a),
    .multpcd (s1_b),
    .product (mult_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      prod          <= '0;
      acc           <= '0;
      ovf           <= 1'b0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.acc_out   <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      // Flush drops the partial frame but leaves any finished result waiting at the output.
      if (bus.clr) begin
        v1  <= 1'b0;
        v2  <= 1'b0;
        acc <= '0;
        ovf <= 1'b0;
        cnt <= '0;
      end else if (!stall) begin
        v1 <= accept;
        if (accept) begin
          s1_a <= bus.multpr;
          s1_b <= bus.multpcd;
        end
        prod <= mult_out;
        v2   <= v1;
        if (v2) begin
          if (last) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
          end else begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
            cnt <= cnt + 1'b1;
          end
        end
      end
      if (frame_end) begin
        bus.acc_out   <= sum[ACC_W-1:0];
        bus.out_ovf   <= ovf | sum[ACC_W];
        bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dadda_mac_accumulator.sv
// Directed and randomized checks of the MAC stage against a frame-sum reference model.
module tb_dadda_mac_accumulator;
  import dadda_mac_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Four instances: 0 = (40,8), 1 = (40,4), 2 = (40,2), 3 = (32,2)
  int len_of  [4] = '{8, 4, 2, 2};
  int accw_of [4] = '{40, 40, 40, 32};

  logic        in_valid  [4];
  logic        out_ready [4];
  logic        clr_s     [4];
  logic [15:0] op_a      [4];
  logic [15:0] op_b      [4];
  logic        ov_s      [4];
  logic        ir_s      [4];
  logic        of_s      [4];
  logic [39:0] ao_s      [4];

  dadda_mac_accumulator_if #(.ACC_W(40)) ifc_a ();
  dadda_mac_accumulator_if #(.ACC_W(40)) ifc_b ();
  dadda_mac_accumulator_if #(.ACC_W(40)) ifc_c ();
  dadda_mac_accumulator_if #(.ACC_W(32)) ifc_d ();

  dadda_mac_accumulator #(.ACC_W(40), .LEN(8)) dut_a (.clk(clk), .rst(rst), .bus(ifc_a));
  dadda_mac_accumulator #(.ACC_W(40), .LEN(4)) dut_b (.clk(clk), .rst(rst), .bus(ifc_b));
  dadda_mac_accumulator #(.ACC_W(40), .LEN(2)) dut_c (.clk(clk), .rst(rst), .bus(ifc_c));
  dadda_mac_accumulator #(.ACC_W(32), .LEN(2)) dut_d (.clk(clk), .rst(rst), .bus(ifc_d));

  assign ifc_a.in_valid = in_valid[0];  assign ifc_a.out_ready = out_ready[0];
  assign ifc_a.clr = clr_s[0];  assign ifc_a.multpr = op_a[0];  assign ifc_a.multpcd = op_b[0];
  assign ifc_b.in_valid = in_valid[1];  assign ifc_b.out_ready = out_ready[1];
  assign ifc_b.clr = clr_s[1];  assign ifc_b.multpr = op_a[1];  assign ifc_b.multpcd = op_b[1];
  assign ifc_c.in_valid = in_valid[2];  assign ifc_c.out_ready = out_ready[2];
  assign ifc_c.clr = clr_s[2];  assign ifc_c.multpr = op_a[2];  assign ifc_c.multpcd = op_b[2];
  assign ifc_d.in_valid = in_valid[3];  assign ifc_d.out_ready = out_ready[3];
  assign ifc_d.clr = clr_s[3];  assign ifc_d.multpr = op_a[3];  assign ifc_d.multpcd = op_b[3];

  assign ov_s[0] = ifc_a.out_valid;  assign ir_s[0] = ifc_a.in_ready;
  assign of_s[0] = ifc_a.out_ovf;    assign ao_s[0] = ifc_a.acc_out;
  assign ov_s[1] = ifc_b.out_valid;  assign ir_s[1] = ifc_b.in_ready;
  assign of_s[1] = ifc_b.out_ovf;    assign ao_s[1] = ifc_b.acc_out;
  assign ov_s[2] = ifc_c.out_valid;  assign ir_s[2] = ifc_c.in_ready;
  assign of_s[2] = ifc_c.out_ovf;    assign ao_s[2] = ifc_c.acc_out;
  assign ov_s[3] = ifc_d.out_valid;  assign ir_s[3] = ifc_d.in_ready;
  assign of_s[3] = ifc_d.out_ovf;    assign ao_s[3] = {8'd0, ifc_d.acc_out};

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] terms[$];
  logic [40:0] exp_q[$];
  int          res_cnt;
  logic [39:0] last_acc;
  logic        last_ovf;
  int          cyc = 0;
  int          last_acc_edge;
  int          rise_cyc;
  logic        prev_ov;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic begin_test(input int k);
    terms.delete();
    exp_q.delete();
    res_cnt  = 0;
    rise_cyc = -1;
    prev_ov  = ov_s[k];
  endtask

  // One clock of instance k: record handshakes at the negedge, then advance past the posedge.
  task automatic step(input int k, output bit took);
    logic [63:0] total;
    logic [63:0] mask;
    logic [40:0] e;
    @(negedge clk);
    took = 1'b0;
    if (in_valid[k] && ir_s[k]) begin
      took = 1'b1;
      last_acc_edge = cyc + 1;
      terms.push_back(64'(op_a[k]) * 64'(op_b[k]));
      if (terms.size() == len_of[k]) begin
        total = 0;
        foreach (terms[i]) total += terms[i];
        mask = (64'd1 << accw_of[k]) - 64'd1;
        exp_q.push_back({((total >> accw_of[k]) != 0), 40'(total & mask)});
        terms.delete();
      end
    end
    if (ov_s[k] && !prev_ov) rise_cyc = cyc;
    prev_ov = ov_s[k];
    if (ov_s[k] && out_ready[k]) begin
      res_cnt++;
      last_acc = ao_s[k];
      last_ovf = of_s[k];
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check($sformatf("sb_result_%0d", k), {of_s[k], ao_s[k]}, e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic feed(input int k, input logic [15:0] a, input logic [15:0] b,
                      input int n, input int budget, output int got);
    bit t;
    got = 0;
    op_a[k] = a;
    op_b[k] = b;
    for (int c = 0; c < budget && got < n; c++) begin
      in_valid[k] = 1'b1;
      step(k, t);
      if (t) got++;
    end
    in_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k, input int n, input int budget);
    bit t;
    for (int c = 0; c < budget && res_cnt < n; c++) step(k, t);
    check($sformatf("drain_count_%0d", k), res_cnt, n);
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, "_out_valid"}, ov_s[k], 0);
    check({tag, "_acc_out"},   ao_s[k], 0);
    check({tag, "_out_ovf"},   of_s[k], 0);
    check({tag, "_in_ready"},  ir_s[k], 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int got;
    int got2;
    int accepted;
    int frames;
    bit t;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b1; clr_s[k] = 1'b0;
      op_a[k] = '0; op_b[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) check_idle(k, $sformatf("por%0d", k));
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a frame discards it.
    begin_test(0);
    feed(0, 16'd1, 16'd1, 3, 10, got);
    rst = 1'b1;
    @(negedge clk);
    check_idle(0, "midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    begin_test(0);
    feed(0, 16'd1, 16'd1, 8, 20, got);
    drain(0, 1, 20);
    check("midrst_acc", last_acc, 8);
    check("midrst_ovf", last_ovf, 0);

    // Back-to-back frame on LEN=4 with latency measurement.
    begin_test(1);
    feed(1, 16'd1, 16'd1, 1, 5, got);
    feed(1, 16'd2, 16'd3, 1, 5, got);
    feed(1, 16'd65535, 16'd65535, 1, 5, got);
    feed(1, 16'd0, 16'd9, 1, 5, got);
    drain(1, 1, 20);
    check("b2b_acc", last_acc, 64'd4294836232);
    check("b2b_ovf", last_ovf, 0);
    check("b2b_latency", rise_cyc - last_acc_edge, 2);

    // Back-pressure on LEN=2.
    begin_test(2);
    out_ready[2] = 1'b0;
    feed(2, 16'd1, 16'd1, 6, 10, got);
    check("bp_accepted_before_stall", got, 4);
    check("bp_in_ready", ir_s[2], 0);
    check("bp_out_valid", ov_s[2], 1);
    check("bp_acc_held", ao_s[2], 2);
    repeat (3) step(2, t);
    check("bp_acc_still_held", ao_s[2], 2);
    out_ready[2] = 1'b1;
    feed(2, 16'd1, 16'd1, 6 - got, 20, got2);
    check("bp_accepted_total", got + got2, 6);
    drain(2, 3, 30);
    check("bp_last_acc", last_acc, 2);
    check("bp_sb_empty", exp_q.size(), 0);

    // Overflow on ACC_W=32, LEN=2, then a clean frame.
    begin_test(3);
    feed(3, 16'd65535, 16'd65535, 2, 10, got);
    drain(3, 1, 20);
    check("ovf_acc", last_acc, 64'd4294705154);
    check("ovf_flag", last_ovf, 1);
    feed(3, 16'd1, 16'd1, 2, 10, got);
    drain(3, 2, 20);
    check("ovf_next_acc", last_acc, 2);
    check("ovf_next_flag", last_ovf, 0);

    // Flush with a simultaneous valid pair on LEN=4.
    begin_test(1);
    feed(1, 16'd100, 16'd100, 2, 10, got);
    clr_s[1] = 1'b1;
    in_valid[1] = 1'b1;
    step(1, t);
    check("clr_no_accept", t, 0);
    check("clr_in_ready", ir_s[1], 0);
    terms.delete();
    clr_s[1] = 1'b0;
    in_valid[1] = 1'b0;
    feed(1, 16'd1, 16'd2, 4, 20, got);
    drain(1, 1, 20);
    check("clr_acc", last_acc, 8);
    check("clr_ovf", last_ovf, 0);

    // Random valid/ready gaps over 1000 frames of LEN=8.
    begin_test(0);
    accepted = 0;
    frames = 1000;
    for (int c = 0; c < 40000 && accepted < frames * 8; c++) begin
      in_valid[0]  = ($urandom_range(0, 3) != 0);
      out_ready[0] = ($urandom_range(0, 3) != 0);
      op_a[0] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      op_b[0] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      step(0, t);
      if (t) accepted++;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    check("rand_accepted", accepted, frames * 8);
    drain(0, frames, 200);
    check("rand_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dadda_mac_accumulator.md
# dadda_mac_accumulator

Pipelined multiply-accumulate stage wrapped around the 16x16 `dadda_multiplier`. It accepts unsigned operand pairs under a valid/ready handshake and registers them into the multiplier. It registers the 32-bit product and sums LEN consecutive products into a wide accumulator. It then presents each completed sum, with a sticky overflow flag, on a valid/ready output port to the downstream dot-product/filter logic.

## Interface
- `ACC_W`, 40: accumulator and result width. Must be ≥ 32.
- `LEN`, 8: products per result (frame length). Must be ≥ 1.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clr`  in  1  synchronous flush of the partial frame.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  stage can accept an operand pair.
- `multpr`  in  16  multiplier operand, unsigned.
- `multpcd`  in  16  multiplicand operand, unsigned.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `acc_out`  out  ACC_W  sum of LEN products, modulo 2^ACC_W.
- `out_ovf`  out  1  a carry out of bit ACC_W-1 occurred while building this result.

## Operation
- Global stall: `stall = out_valid & ~out_ready`. All pipeline registers hold while stalled.
- `in_ready = ~stall & ~clr`. An operand pair is accepted when `in_valid & in_ready`.
- S1 (operand regs): on accept, latch `multpr`/`multpcd` and set `v1`. If not stalled and nothing is accepted, clear `v1`.
- S2 (product reg): if not stalled, `prod <= dadda_multiplier(S1 operands)` and `v2 <= v1`.
- S3 (accumulate): if not stalled and `v2`, compute `sum = acc + prod` at ACC_W+1 bits. The top bit ORs into a sticky `ovf`. `cnt` counts 0..LEN-1.
  - When `cnt != LEN-1`: `acc <= sum[ACC_W-1:0]` and `cnt` increments.
  - When `cnt == LEN-1`, this is the frame end:
    - Load `acc_out <= sum[ACC_W-1:0]` and `out_ovf <= ovf | carry`, and set `out_valid`.
    - Clear `acc`, `ovf` and `cnt` to 0 in the same edge.
- Output register: `out_valid` clears on `out_valid & out_ready` unless a new frame ends in that same edge. In that case the new result loads and `out_valid` stays 1.
- `clr` (not stalled or stalled): clears `v1`, `v2`, `acc`, `ovf` and `cnt` at the edge. The output register is unaffected. `clr` together with `in_valid` means no accept, because `clr` wins.
- Arithmetic is unsigned only, and the accumulator wraps modulo 2^ACC_W.
- When LEN = 1, every product is a frame end.

## Timing
- Reset values, held while `rst` is high:
  - `v1`, `v2`, `acc`, `cnt` and `ovf` are 0.
  - `out_valid` = 0, `acc_out` = 0, `out_ovf` = 0.
  - `in_ready` = 1 whenever `clr` is low, since `stall` = 0.
- Reset mid-frame discards the partial frame and any pending result.
- Throughput: one pair per cycle with no bubbles while `out_ready` is held high.
- Latency: for a last term accepted at edge k, `out_valid` is high after edge k+2.
- While stalled, `acc_out` and `out_ovf` are stable, and no term is lost or duplicated.
- Gaps in `in_valid` do not affect the result, only its timing.
- Multiplier combinational delay lies between S1 and S2 and must fit in one `clk` period.

## Structure
- Package `dadda_mac_pkg` holds:
  - constants `OP_W = 16` and `PROD_W = 32`;
  - default `ACC_W` and `LEN`;
  - `CNT_W = $clog2(LEN)`, minimum 1.
- Sub-module: the existing `dadda_multiplier` (ports `multpr`, `multpcd`, `product`), instantiated once between S1 and S2. All other logic stays flat in this module.

## Test plan
- Reset: assert `rst` after 3 of 8 terms.
  - Required: outputs read 0 and `in_ready` = 1.
  - Then 8 pairs (1,1): `acc_out` = 8, `out_ovf` = 0.
- LEN=4, ACC_W=40, back-to-back pairs (1,1), (2,3), (65535,65535), (0,9).
  - Required: `acc_out` = 4294836232 and `out_ovf` = 0.
  - `out_valid` rises 2 cycles after the last accept.
- Back-pressure: LEN=2, `out_ready` = 0, stream 6 pairs (1,1).
  - After the first result, `in_ready` drops.
  - `acc_out` holds 2, with no lost or duplicated terms.
  - Raise `out_ready`: three results of 2 follow, one per accepted frame.
- Overflow: ACC_W=32, LEN=2, pairs (65535,65535) ×2.
  - Required: `acc_out` = 4294705154 and `out_ovf` = 1.
  - Next frame of (1,1) ×2: `acc_out` = 2 and `out_ovf` = 0.
- `clr`: LEN=4, accept (100,100) ×2, pulse `clr` with `in_valid` = 1.
  - Required: that pair is not accepted.
  - Then (1,2) ×4: `acc_out` = 8.
- Random `in_valid`/`out_ready` gaps over 1000 random frames.
  - Required: every result equals the reference sum of LEN products modulo 2^ACC_W.
